// File: rtl/basilisk_writeback_arbiter_pkg.sv
// Shared types and constants for the Basilisk writeback merge stage.
// Optional feature macro: BASILISK_WRITEBACK_BYPASS_EN (see top module).
package basilisk_writeback_arbiter_pkg;

  localparam int BASILISK_WRITEBACK_CHANNELS = 6;
  localparam int REG_W = 5;
  localparam int OFF_W = 3;
  localparam int VAL_W = 32;

  typedef enum logic [2:0] {
    ADD     = 3'd0,
    MULT    = 3'd1,
    DIVIDE  = 3'd2,
    SQRT    = 3'd3,
    CONVERT = 3'd4,
    MEMORY  = 3'd5
  } basilisk_writeback_channel_t;

  typedef struct packed {
    logic [REG_W-1:0] reg_addr;
    logic [OFF_W-1:0] offset;
    logic [VAL_W-1:0] value;
  } basilisk_writeback_result_t;

  // Channel index width, never below one bit.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/basilisk_writeback_arbiter_if.sv
// Producer-side and register-file-side signals of the writeback merge stage.
// slave = the arbiter, master = the surrounding environment.
interface basilisk_writeback_arbiter_if
  import basilisk_writeback_arbiter_pkg::*;
#(
  parameter int CHANNELS = BASILISK_WRITEBACK_CHANNELS
) ();

  localparam int CW = chan_width(CHANNELS);

  logic [CHANNELS-1:0]                       in_valid;
  logic [CHANNELS-1:0]                       in_ready;
  basilisk_writeback_result_t [CHANNELS-1:0] in_data;
  logic                                      out_valid;
  logic                                      out_ready;
  basilisk_writeback_result_t                out_data;
  logic [CW-1:0]                             out_channel;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_channel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_channel
  );

endinterface

// File: rtl/basilisk_writeback_arbiter_fifo.sv
// Per-channel result FIFO; ready comes from the registered count only, so a
// pop never re-opens the input in the same cycle.
module basilisk_result_fifo
  import basilisk_writeback_arbiter_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = basilisk_writeback_result_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic ready
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;

  assign empty = (count == '0);
  assign ready = (count != (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/basilisk_writeback_arbiter.sv
// N-channel round-robin merge of execution-unit results into one registered
// writeback stream. BASILISK_WRITEBACK_BYPASS_EN lets an empty channel skip its FIFO.
module basilisk_writeback_arbiter
  import basilisk_writeback_arbiter_pkg::*;
#(
  parameter int CHANNELS = BASILISK_WRITEBACK_CHANNELS,
  parameter int DEPTH    = 2
) (
  input logic clk,
  input logic rst,
  basilisk_writeback_arbiter_if.slave bus
);

  localparam int CW = chan_width(CHANNELS);

  logic [CHANNELS-1:0]                       empty, ready, push, pop, req;
  basilisk_writeback_result_t [CHANNELS-1:0] head;
  basilisk_writeback_result_t                sel;
  logic [CW-1:0]                             rr_ptr, gnt, gnt_next;
  logic [CW:0]                               idx;
  logic                                      found, load, take;

  assign bus.in_ready = ready;
  assign load = ~bus.out_valid | bus.out_ready;
  assign take = load & found;
  assign gnt_next = (gnt == CW'(CHANNELS-1)) ? '0 : gnt + 1'b1;

`ifdef BASILISK_WRITEBACK_BYPASS_EN
  logic bypass;
  assign req    = ~empty | bus.in_valid;
  assign bypass = empty[gnt];
  assign sel    = bypass ? bus.in_data[gnt] : head[gnt];
`else
  assign req = ~empty;
  assign sel = head[gnt];
`endif

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      idx = {1'b0, rr_ptr} + (CW+1)'(off);
      if (idx >= (CW+1)'(CHANNELS)) idx = idx - (CW+1)'(CHANNELS);
      if (!found && req[idx[CW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[CW-1:0];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign pop[g] = take & (gnt == CW'(g)) & ~empty[g];
`ifdef BASILISK_WRITEBACK_BYPASS_EN
    assign push[g] = bus.in_valid[g] & ready[g] & ~(take & bypass & (gnt == CW'(g)));
`else
    assign push[g] = bus.in_valid[g] & ready[g];
`endif

    basilisk_result_fifo #(
      .DEPTH (DEPTH),
      .T     (basilisk_writeback_result_t)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (bus.in_data[g]),
      .pop       (pop[g]),
      .head      (head[g]),
      .empty     (empty[g]),
      .ready     (ready[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_channel <= '0;
      rr_ptr          <= '0;
    end else if (load) begin
      bus.out_valid <= found;
      if (found) begin
        bus.out_data    <= sel;
        bus.out_channel <= gnt;
        rr_ptr          <= gnt_next;
      end
    end
  end

endmodule

// File: tb/tb_basilisk_writeback_arbiter.sv
// Directed bench for the writeback merge stage (default build): a 6x2 instance
// and a 1x4 instance share clock and reset.
module tb_basilisk_writeback_arbiter;
  import basilisk_writeback_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   sent;

  always #5 clk = ~clk;

  basilisk_writeback_arbiter_if #(.CHANNELS(6)) bus0 ();
  basilisk_writeback_arbiter_if #(.CHANNELS(1)) bus1 ();

  basilisk_writeback_arbiter #(.CHANNELS(6), .DEPTH(2)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  basilisk_writeback_arbiter #(.CHANNELS(1), .DEPTH(4)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    bus0.in_valid = '0;
    bus1.in_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus0.in_valid = '0; bus0.in_data = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = '0; bus1.in_data = '0; bus1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid",   64'(bus0.out_valid),   64'd0);
    chk("rst_out_data",    64'(bus0.out_data),    64'd0);
    chk("rst_out_channel", 64'(bus0.out_channel), 64'd0);
    chk("rst_in_ready",    64'(bus0.in_ready),    64'h3f);
    chk("rst_in_ready_c1", 64'(bus1.in_ready),    64'd1);
    rst = 1'b0;

    // Single channel latency and payload
    @(negedge clk);
    bus0.in_valid   = 6'b000100;
    bus0.in_data[2] = '{reg_addr: 5'd5, offset: 3'd1, value: 32'h3F800000};
    @(negedge clk);
    bus0.in_valid = '0;
    chk("lat_k1_valid", 64'(bus0.out_valid), 64'd0);
    @(negedge clk);
    chk("lat_k2_valid", 64'(bus0.out_valid),   64'd1);
    chk("lat_channel",  64'(bus0.out_channel), 64'd2);
    chk("lat_payload",  64'(bus0.out_data),    {24'd0, 5'd5, 3'd1, 32'h3F800000});
    @(negedge clk);
    chk("lat_drain", 64'(bus0.out_valid), 64'd0);

    // Round robin with all channels requesting every cycle
    do_reset();
    for (int c = 0; c < 6; c++)
      bus0.in_data[c] = '{reg_addr: 5'(c), offset: 3'd0, value: 32'h100 + 32'(c)};
    bus0.in_valid = 6'h3f;
    @(negedge clk);
    chk("rr_fill", 64'(bus0.out_valid), 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rr_valid", 64'(bus0.out_valid),      64'd1);
      chk("rr_chan",  64'(bus0.out_channel),    64'(i % 6));
      chk("rr_data",  64'(bus0.out_data.value), 64'h100 + 64'(i % 6));
    end
    bus0.in_valid = '0;

    // Back-pressure while channel 1 streams
    do_reset();
    bus0.out_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc >= 2) begin
        chk("bp_stall_valid", 64'(bus0.out_valid),      64'd1);
        chk("bp_stall_data",  64'(bus0.out_data.value), 64'hA000);
      end
      if (bus0.in_ready[1]) begin
        bus0.in_valid = 6'b000010;
        bus0.in_data[1] = '{reg_addr: 5'd1, offset: 3'd2, value: 32'hA000 + 32'(sent)};
        sent++;
      end else begin
        bus0.in_valid = '0;
      end
      @(negedge clk);
    end
    bus0.in_valid = '0;
    chk("bp_in_ready_low", 64'(bus0.in_ready[1]), 64'd0);
    chk("bp_accepted",     64'(sent),             64'd3);
    bus0.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("bp_rel_valid", 64'(bus0.out_valid),      64'd1);
      chk("bp_rel_data",  64'(bus0.out_data.value), 64'hA000 + 64'(j));
      @(negedge clk);
    end
    chk("bp_rel_end",  64'(bus0.out_valid),   64'd0);
    chk("bp_in_ready", 64'(bus0.in_ready[1]), 64'd1);

    // Full boundary on channel 3
    do_reset();
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 6'b001000;
    bus0.in_data[3] = '{reg_addr: 5'd3, offset: 3'd0, value: 32'hB000};
    @(negedge clk);
    chk("full_rdy1", 64'(bus0.in_ready[3]), 64'd1);
    bus0.in_data[3].value = 32'hB001;
    @(negedge clk);
    chk("full_rdy2", 64'(bus0.in_ready[3]), 64'd1);
    bus0.in_data[3].value = 32'hB002;
    @(negedge clk);
    chk("full_low",   64'(bus0.in_ready[3]),   64'd0);
    chk("full_head0", 64'(bus0.out_data.value), 64'hB000);
    bus0.in_data[3].value = 32'hB003;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("full_rise", 64'(bus0.in_ready[3]),    64'd1);
    chk("full_out1", 64'(bus0.out_data.value), 64'hB001);
    @(negedge clk);
    bus0.in_valid = '0;
    chk("full_out2", 64'(bus0.out_data.value), 64'hB002);
    @(negedge clk);
    chk("full_out3_valid", 64'(bus0.out_valid),      64'd1);
    chk("full_out3",       64'(bus0.out_data.value), 64'hB003);
    @(negedge clk);
    chk("full_end", 64'(bus0.out_valid), 64'd0);

    // Asynchronous reset with three results buffered
    do_reset();
    bus0.out_ready = 1'b0;
    for (int c = 0; c < 3; c++)
      bus0.in_data[c] = '{reg_addr: 5'(c), offset: 3'd0, value: 32'hC000 + 32'(c)};
    bus0.in_valid = 6'b000111;
    @(negedge clk);
    bus0.in_valid = '0;
    @(negedge clk);
    chk("ar_pre_valid", 64'(bus0.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid_async", 64'(bus0.out_valid), 64'd0);
    chk("ar_in_ready",    64'(bus0.in_ready),  64'h3f);
    @(negedge clk);
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ar_no_stale", 64'(bus0.out_valid), 64'd0);
    end

    // CHANNELS=1, DEPTH=4: eight back-to-back results
    bus1.out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t >= 2 && t < 10) begin
        chk("c1_valid",   64'(bus1.out_valid),      64'd1);
        chk("c1_data",    64'(bus1.out_data.value), 64'hD000 + 64'((t - 2) * 3));
        chk("c1_channel", 64'(bus1.out_channel),    64'd0);
      end else begin
        chk("c1_idle", 64'(bus1.out_valid), 64'd0);
      end
      if (t < 8) begin
        chk("c1_in_ready", 64'(bus1.in_ready), 64'd1);
        bus1.in_valid = 1'b1;
        bus1.in_data[0] = '{reg_addr: 5'd7, offset: 3'd4, value: 32'hD000 + 32'(t * 3)};
      end else begin
        bus1.in_valid = 1'b0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
